// File: rtl/lif_param_loader.sv
// Byte-serial, checksum-protected configuration loader feeding the LIF neuron.
// A frame commits all fields at once; failed frames leave the old values in use.
module lif_param_loader #(
    parameter logic [2:0]  DEF_WEIGHT_A   = 3'd3,
    parameter logic [2:0]  DEF_WEIGHT_B   = 3'd3,
    parameter logic [1:0]  DEF_LEAK       = 2'd1,
    parameter logic [7:0]  DEF_THR_MIN    = 8'd20,
    parameter logic [7:0]  DEF_THR_MAX    = 8'd120,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [2:0] weight_a,
    output logic [2:0] weight_b,
    output logic [1:0] leak_config,
    output logic [7:0] threshold_min,
    output logic [7:0] threshold_max,
    output logic       params_ready,
    output logic       cfg_update,
    output logic       err_checksum,
    output logic       err_range,
    output logic       err_timeout,
    output logic [7:0] frame_count
);

    // state    | meaning
    // IDLE     | hunting for HEADER, other bytes dropped
    // GET_CFG  | waiting for packed weight/leak byte
    // GET_TMIN | waiting for minimum threshold
    // GET_TMAX | waiting for maximum threshold
    // GET_CSUM | waiting for checksum byte
    // CHECK    | one cycle: verify checksum then range
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_CFG  = 3'd1;
    localparam logic [2:0] S_GET_TMIN = 3'd2;
    localparam logic [2:0] S_GET_TMAX = 3'd3;
    localparam logic [2:0] S_GET_CSUM = 3'd4;
    localparam logic [2:0] S_CHECK    = 3'd5;

    logic [2:0]  state;
    logic [7:0]  sh_cfg;
    logic [7:0]  sh_tmin;
    logic [7:0]  sh_tmax;
    logic [7:0]  sh_csum;
    logic [15:0] tmo_cnt;
    logic        do_commit;
    logic        do_csum_err;
    logic        do_range_err;
    logic        accept;
    logic        csum_ok;
    logic        range_ok;

    assign accept   = data_valid && data_ready;
    assign csum_ok  = (sh_csum == (sh_cfg ^ sh_tmin ^ sh_tmax));
    assign range_ok = (sh_tmin <= sh_tmax);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            sh_cfg        <= 8'd0;
            sh_tmin       <= 8'd0;
            sh_tmax       <= 8'd0;
            sh_csum       <= 8'd0;
            tmo_cnt       <= 16'd0;
            do_commit     <= 1'b0;
            do_csum_err   <= 1'b0;
            do_range_err  <= 1'b0;
            data_ready    <= 1'b1;
            weight_a      <= DEF_WEIGHT_A;
            weight_b      <= DEF_WEIGHT_B;
            leak_config   <= DEF_LEAK;
            threshold_min <= DEF_THR_MIN;
            threshold_max <= DEF_THR_MAX;
            params_ready  <= 1'b0;
            cfg_update    <= 1'b0;
            err_checksum  <= 1'b0;
            err_range     <= 1'b0;
            err_timeout   <= 1'b0;
            frame_count   <= 8'd0;
        end else begin
            // The CHECK verdict is staged one cycle so results land on the
            // second edge after the checksum byte is taken.
            cfg_update   <= do_commit;
            err_checksum <= do_csum_err;
            err_range    <= do_range_err;
            err_timeout  <= 1'b0;
            do_commit    <= 1'b0;
            do_csum_err  <= 1'b0;
            do_range_err <= 1'b0;

            if (do_commit) begin
                weight_a      <= sh_cfg[7:5];
                weight_b      <= sh_cfg[4:2];
                leak_config   <= sh_cfg[1:0];
                threshold_min <= sh_tmin;
                threshold_max <= sh_tmax;
                params_ready  <= 1'b1;
                if (frame_count != 8'hFF)
                    frame_count <= frame_count + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    tmo_cnt <= 16'd0;
                    if (accept && data_in == HEADER)
                        state <= S_GET_CFG;
                end
                S_GET_CFG, S_GET_TMIN, S_GET_TMAX, S_GET_CSUM: begin
                    if (accept) begin
                        tmo_cnt <= 16'd0;
                        case (state)
                            S_GET_CFG:  begin sh_cfg  <= data_in; state <= S_GET_TMIN; end
                            S_GET_TMIN: begin sh_tmin <= data_in; state <= S_GET_TMAX; end
                            S_GET_TMAX: begin sh_tmax <= data_in; state <= S_GET_CSUM; end
                            default: begin
                                sh_csum    <= data_in;
                                state      <= S_CHECK;
                                data_ready <= 1'b0;
                            end
                        endcase
                    end else if (tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                        tmo_cnt     <= 16'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    state      <= S_IDLE;
                    data_ready <= 1'b1;
                    if (!csum_ok)
                        do_csum_err <= 1'b1;
                    else if (!range_ok)
                        do_range_err <= 1'b1;
                    else
                        do_commit <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    data_ready <= 1'b1;
                    tmo_cnt    <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_param_loader.sv
// Bench for lif_param_loader: directed frames plus randomized frames compared
// against a frame-level model of the committed parameter set.
module tb_lif_param_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [2:0] weight_a;
    logic [2:0] weight_b;
    logic [1:0] leak_config;
    logic [7:0] threshold_min;
    logic [7:0] threshold_max;
    logic       params_ready;
    logic       cfg_update;
    logic       err_checksum;
    logic       err_range;
    logic       err_timeout;
    logic [7:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    int m_wa, m_wb, m_lk, m_tmin, m_tmax, m_rdy, m_cnt;

    lif_param_loader dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .weight_a(weight_a), .weight_b(weight_b),
        .leak_config(leak_config), .threshold_min(threshold_min),
        .threshold_max(threshold_max), .params_ready(params_ready),
        .cfg_update(cfg_update), .err_checksum(err_checksum), .err_range(err_range),
        .err_timeout(err_timeout), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_defaults();
        m_wa = 3; m_wb = 3; m_lk = 1; m_tmin = 20; m_tmax = 120; m_rdy = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".weight_a"}, 32'(weight_a), 32'(m_wa));
        chk({tag, ".weight_b"}, 32'(weight_b), 32'(m_wb));
        chk({tag, ".leak"}, 32'(leak_config), 32'(m_lk));
        chk({tag, ".tmin"}, 32'(threshold_min), 32'(m_tmin));
        chk({tag, ".tmax"}, 32'(threshold_max), 32'(m_tmax));
        chk({tag, ".params_ready"}, 32'(params_ready), 32'(m_rdy));
        chk({tag, ".frame_count"}, 32'(frame_count), 32'(m_cnt));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".cfg_update"}, 32'(cfg_update), 0);
        chk({tag, ".err_checksum"}, 32'(err_checksum), 0);
        chk({tag, ".err_range"}, 32'(err_range), 0);
        chk({tag, ".err_timeout"}, 32'(err_timeout), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        data_valid = 1'b0;
        tick();
        tick();
        model_defaults();
        check_outputs("in_reset");
        check_quiet("in_reset");
        reset = 1'b1;
        chk("ready_after_reset", 32'(data_ready), 1);
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        data_valid = 1'b0;
        repeat (gap) tick();
        data_in = b;
        data_valid = 1'b1;
        budget = 0;
        while (!data_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (!data_ready)
            chk("ready_wait", 32'(data_ready), 1);
        else
            tick();
        data_valid = 1'b0;
    endtask

    // Frame-level verdict: 0 commit, 1 checksum error, 2 range error.
    function automatic int verdict(input int cfg, input int tmin, input int tmax, input int csum);
        if (csum != (cfg ^ tmin ^ tmax)) return 1;
        if (tmin > tmax) return 2;
        return 0;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] cfg, input logic [7:0] tmin,
                             input logic [7:0] tmax, input logic [7:0] csum, input int gap);
        int v;
        v = verdict(int'(cfg), int'(tmin), int'(tmax), int'(csum));
        send_byte(8'hA5, gap);
        send_byte(cfg, gap);
        send_byte(tmin, gap);
        send_byte(tmax, gap);
        send_byte(csum, gap);
        chk({tag, ".ready_in_check"}, 32'(data_ready), 0);
        check_outputs({tag, ".hold0"});
        tick();
        chk({tag, ".ready_after_check"}, 32'(data_ready), 1);
        check_quiet({tag, ".early"});
        check_outputs({tag, ".hold1"});
        tick();
        if (v == 0) begin
            m_wa = int'(cfg) / 32;
            m_wb = (int'(cfg) / 4) % 8;
            m_lk = int'(cfg) % 4;
            m_tmin = int'(tmin);
            m_tmax = int'(tmax);
            m_rdy = 1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        chk({tag, ".cfg_update"}, 32'(cfg_update), (v == 0) ? 1 : 0);
        chk({tag, ".err_checksum"}, 32'(err_checksum), (v == 1) ? 1 : 0);
        chk({tag, ".err_range"}, 32'(err_range), (v == 2) ? 1 : 0);
        check_outputs({tag, ".result"});
        tick();
        check_quiet({tag, ".after"});
    endtask

    initial begin
        logic [7:0] c, a, b, lo, hi, j;
        int kind;
        model_defaults();

        do_reset();
        run_frame("good", 8'h76, 8'h14, 8'h78, 8'h1A, 0);

        do_reset();
        run_frame("bad_csum", 8'h76, 8'h14, 8'h78, 8'h1B, 0);

        run_frame("bad_range", 8'h00, 8'h80, 8'h10, 8'h90, 0);
        run_frame("equal_thr", 8'hFF, 8'h40, 8'h40, 8'hFF, 0);
        run_frame("hdr_as_data", 8'hA5, 8'h10, 8'h20, 8'hA5 ^ 8'h10 ^ 8'h20, 0);

        // Stall mid-frame until the timeout abandons it.
        send_byte(8'hA5, 0);
        send_byte(8'h76, 0);
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (i == 999) chk("tmo_early", 32'(err_timeout), 0);
            if (i == 1000) chk("tmo_pulse", 32'(err_timeout), 1);
        end
        tick();
        chk("tmo_clear", 32'(err_timeout), 0);
        chk("tmo_ready", 32'(data_ready), 1);
        check_outputs("tmo_hold");
        run_frame("after_tmo", 8'h76, 8'h14, 8'h78, 8'h1A, 0);

        send_byte(8'h00, 0);
        send_byte(8'h3C, 0);
        tick();
        check_quiet("junk");
        check_outputs("junk");
        run_frame("toggle", 8'h2D, 8'h05, 8'hF0, 8'h2D ^ 8'h05 ^ 8'hF0, 1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h00;
                send_byte(j, 0);
            end
            c = 8'($urandom_range(0, 255));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            lo = (a < b) ? a : b;
            hi = (a < b) ? b : a;
            kind = int'($urandom_range(0, 3));
            if (kind == 2)
                run_frame("rnd_csum", c, lo, hi, (c ^ lo ^ hi) ^ 8'($urandom_range(1, 255)),
                          int'($urandom_range(0, 2)));
            else if (kind == 3 && lo != hi)
                run_frame("rnd_range", c, hi, lo, c ^ hi ^ lo, int'($urandom_range(0, 2)));
            else
                run_frame("rnd_good", c, lo, hi, c ^ lo ^ hi, int'($urandom_range(0, 2)));
        end

        for (int n = 0; n < 260; n++) begin
            c = 8'($urandom_range(0, 255));
            run_frame("sat", c, 8'd1, 8'd200, c ^ 8'd1 ^ 8'd200, 0);
        end
        chk("sat_count", 32'(frame_count), 255);

        // Reset in the middle of a frame after a prior commit.
        send_byte(8'hA5, 0);
        send_byte(8'h76, 0);
        send_byte(8'h14, 0);
        do_reset();
        send_byte(8'h78, 0);
        send_byte(8'h1A, 0);
        tick();
        tick();
        tick();
        check_quiet("post_reset");
        check_outputs("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
